key_events: RTL and testbench
=============================

KEY_EVENTS -- requirements
Module: key_events

Interface
REQ-001 The module SHALL have parameter w, default 1, giving the number of independent key channels.
REQ-002 The module SHALL have parameter hold_cycles, default 1000, giving the cycles from press to the first auto-repeat strobe; legal values are 1 and above.
REQ-003 The module SHALL have parameter repeat_cycles, default 250, giving the cycles between auto-repeat strobes; legal values are 1 and above.
REQ-004 The ports SHALL be as follows:
- clk  input  1  the single clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- key  input  w  debounced, synchronised key levels, active-high.
- press  output  w  one-cycle pulse on key press.
- release  output  w  one-cycle pulse on key release.
- strobe  output  w  one-cycle pulse on press and on each auto-repeat.
- held  output  w  level, high while the channel is in auto-repeat.

Function
REQ-005 Each channel SHALL run an independent FSM with states IDLE, PRESSED and REPEAT, plus a per-channel counter of width clog2(max(hold_cycles, repeat_cycles)).
REQ-006 In IDLE, key=1 sampled at edge k SHALL move the channel to PRESSED, clear the counter, and drive press=1 and strobe=1 for the cycle after edge k.
REQ-007 In PRESSED with key=1, the counter SHALL increment each cycle; when counter==hold_cycles-1, the channel SHALL move to REPEAT, clear the counter and pulse strobe.
REQ-008 In REPEAT with key=1, the counter SHALL increment each cycle; when counter==repeat_cycles-1, it SHALL clear and pulse strobe; held SHALL be 1 throughout REPEAT.
REQ-009 In PRESSED or REPEAT, key=0 SHALL move the channel to IDLE and pulse release for one cycle.
REQ-010 Release SHALL have priority over a simultaneous counter terminal count: no strobe is issued and the channel goes to IDLE.
REQ-011 All outputs SHALL be registered; each pulse SHALL be exactly one cycle wide, with latency one cycle from the sampling edge.
REQ-012 press and release SHALL never be high in the same cycle on the same channel.
REQ-013 A one-cycle key high SHALL yield press then release on consecutive cycles.
REQ-014 The counter SHALL never wrap; it is cleared on every state entry and at each terminal count.
REQ-015 With hold_cycles=1, strobe SHALL pulse on consecutive cycles: press, then the first repeat.
REQ-016 Channels SHALL NOT interact; simultaneous events on different channels SHALL each be reported in the same cycle.

Reset
REQ-017 While reset_n=0 at a clock edge, every channel SHALL enter IDLE, the counter SHALL clear, and press, release, strobe and held SHALL be 0 from the next cycle.
REQ-018 Reset asserted mid-hold SHALL NOT generate a release pulse.
REQ-019 A key already high when reset deasserts SHALL produce press one cycle after the first edge sampled with reset_n=1.

Structure
REQ-020 State encodings and the counter-width function SHALL live in the shared package key_events_pkg.
REQ-021 Per-channel logic SHALL be the sub-module key_events_one, instantiated w times by a generate loop in key_events.
REQ-022 The key input SHALL be driven directly from the debounced switch outputs; key_events SHALL add no synchroniser.

Verification (w=2, hold_cycles=4, repeat_cycles=2)
REQ-023 key[0] rises, sampled at edge 10, held for 12 cycles -> press[0] in cycle 11; strobe[0] in cycles 11, 15, 17, 19, 21; held[0] from cycle 15; release[0] one cycle after the first key=0 sample.
REQ-024 key[1] high for exactly 1 cycle at edge 5 -> press[1] in cycle 6, release[1] in cycle 7, one strobe only, held[1] never 1.
REQ-025 key[0] falls on the edge where the counter reaches 3 in PRESSED -> release[0] pulses and no strobe is issued in that cycle.
REQ-026 reset_n=0 for 1 cycle while key[0] is in REPEAT -> all outputs 0 next cycle with no release; key still high -> press one cycle after the first reset_n=1 edge.
REQ-027 Both keys rise at the same edge -> press=2'b11 and strobe=2'b11 in the same cycle, with identical repeat timing thereafter.

Source files
------------

// File: rtl/key_events_pkg.sv
// Shared definitions for the key event generator: per-channel FSM states
// and the sizing rule for the hold/repeat counter.
package key_events_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } key_state_t;

    // The counter only ever holds values up to max(hold, repeat)-1.
    // It is kept at least one bit wide so the hold=repeat=1 case still has a legal vector.
    function automatic int cnt_width(input int hold, input int rep);
        int m;
        m = (hold > rep) ? hold : rep;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_events_one.sv
// One key channel: press/release edge pulses plus a hold-then-repeat strobe.
// All outputs are registered, so each pulse appears one cycle after its sampling edge.
module key_events_one
    import key_events_pkg::*;
#(
    parameter int HOLD = 1000,
    parameter int REP  = 250,
    parameter int CW   = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key,
    output logic press,
    output logic key_release,
    output logic strobe,
    output logic held
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP - 1);

    key_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          press_nx, release_nx, strobe_nx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            press       <= 1'b0;
            key_release <= 1'b0;
            strobe      <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            press       <= press_nx;
            key_release <= release_nx;
            strobe      <= strobe_nx;
            held        <= (state_nx == REPEAT);
        end
    end

    // A low key is checked before the terminal count, so release always beats a strobe.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        strobe_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (key) begin
                    state_nx  = PRESSED;
                    cnt_nx    = '0;
                    press_nx  = 1'b1;
                    strobe_nx = 1'b1;
                end
            end
            PRESSED: begin
                if (!key) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    release_nx = 1'b1;
                end else if (cnt == HOLD_LAST) begin
                    state_nx  = REPEAT;
                    cnt_nx    = '0;
                    strobe_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!key) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    release_nx = 1'b1;
                end else if (cnt == REP_LAST) begin
                    cnt_nx    = '0;
                    strobe_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_events.sv
// Array of independent key channels. "release" is a reserved word, so the
// release pulse port is named key_release.
module key_events
    import key_events_pkg::*;
#(
    parameter int w             = 1,
    parameter int hold_cycles   = 1000,
    parameter int repeat_cycles = 250
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [w-1:0] key,
    output logic [w-1:0] press,
    output logic [w-1:0] key_release,
    output logic [w-1:0] strobe,
    output logic [w-1:0] held
);

    localparam int CW = cnt_width(hold_cycles, repeat_cycles);

    for (genvar i = 0; i < w; i++) begin : g_ch
        key_events_one #(
            .HOLD (hold_cycles),
            .REP  (repeat_cycles),
            .CW   (CW)
        ) u_one (
            .clk         (clk),
            .reset_n     (reset_n),
            .key         (key[i]),
            .press       (press[i]),
            .key_release (key_release[i]),
            .strobe      (strobe[i]),
            .held        (held[i])
        );
    end

endmodule

// File: tb/tb_key_events.sv
// Bench for key_events: a w=2 (hold 4, repeat 2) instance plus a w=1 (hold 1, repeat 1)
// instance sharing key[0], checked against a run-length reference model.
module tb_key_events;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] key = 2'b00;
    logic [1:0] press, key_release, strobe, held;
    logic [0:0] press1, release1, strobe1, held1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_events #(.w(2), .hold_cycles(4), .repeat_cycles(2)) dut (
        .clk(clk), .reset_n(reset_n), .key(key),
        .press(press), .key_release(key_release), .strobe(strobe), .held(held)
    );

    key_events #(.w(1), .hold_cycles(1), .repeat_cycles(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .key(key[0:0]),
        .press(press1), .key_release(release1), .strobe(strobe1), .held(held1)
    );

    // Model: run[c] = number of consecutive high samples since the last low or reset.
    // Channels 0,1 model dut; channel 2 models dut1.
    int run [3] = '{0, 0, 0};
    bit mp [3], mr [3], ms [3], mh [3];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive, let one edge sample, advance the model, check at the next negedge.
    task automatic step(input bit rst_i, input bit [1:0] key_i);
        reset_n = rst_i;
        key     = key_i;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            bit k;
            int h, r;
            k = (c == 2) ? key_i[0] : key_i[c];
            h = (c == 2) ? 1 : 4;
            r = (c == 2) ? 1 : 2;
            mp[c] = 0; mr[c] = 0; ms[c] = 0; mh[c] = 0;
            if (!rst_i) begin
                run[c] = 0;
            end else if (!k) begin
                mr[c]  = (run[c] > 0);
                run[c] = 0;
            end else begin
                run[c]++;
                mp[c] = (run[c] == 1);
                mh[c] = (run[c] - 1 >= h);
                ms[c] = mp[c] || (mh[c] && ((run[c] - 1 - h) % r == 0));
            end
        end
        @(negedge clk);
        chk("model_press",   press,       {mp[1], mp[0]});
        chk("model_release", key_release, {mr[1], mr[0]});
        chk("model_strobe",  strobe,      {ms[1], ms[0]});
        chk("model_held",    held,        {mh[1], mh[0]});
        chk("model1_press",   {1'b0, press1},   {1'b0, mp[2]});
        chk("model1_release", {1'b0, release1}, {1'b0, mr[2]});
        chk("model1_strobe",  {1'b0, strobe1},  {1'b0, ms[2]});
        chk("model1_held",    {1'b0, held1},    {1'b0, mh[2]});
    endtask

    typedef struct {
        bit       rst_n;
        bit [1:0] key;
        bit [1:0] press, rel, strb, held;
    } vec_t;

    vec_t tbl [21];

    initial begin
        // rst, key, press, release, strobe, held  (expected after that edge)
        tbl[0]  = '{0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{1, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00};
        tbl[4]  = '{1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        tbl[5]  = '{1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00};
        tbl[7]  = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};
        tbl[11] = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
        tbl[12] = '{1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};
        tbl[13] = '{1, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        tbl[14] = '{1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        tbl[15] = '{1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[16] = '{1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
        tbl[17] = '{1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[18] = '{1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[19] = '{1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        // key drops exactly when the hold counter would hit terminal count
        tbl[20] = '{1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].key);
            chk("tbl_press",   press,       tbl[i].press);
            chk("tbl_release", key_release, tbl[i].rel);
            chk("tbl_strobe",  strobe,      tbl[i].strb);
            chk("tbl_held",    held,        tbl[i].held);
        end

        // Long hold on key[0]: strobes on samples 1,5,7,9,11; held from sample 5.
        step(1, 2'b00);
        for (int j = 1; j <= 12; j++) begin
            step(1, 2'b01);
            chk("hold_strobe", {1'b0, strobe[0]},
                {1'b0, (j == 1 || j == 5 || j == 7 || j == 9 || j == 11) ? 1'b1 : 1'b0});
            chk("hold_held",  {1'b0, held[0]},  {1'b0, (j >= 5) ? 1'b1 : 1'b0});
            chk("hold_press", {1'b0, press[0]}, {1'b0, (j == 1) ? 1'b1 : 1'b0});
            chk("h1_strobe",  {1'b0, strobe1},  2'b01);
        end
        step(1, 2'b00);
        chk("hold_release", key_release, 2'b01);
        chk("hold_release_strobe", strobe, 2'b00);

        // Reset while in REPEAT: silent clear, then fresh press with key still high.
        for (int j = 0; j < 6; j++) step(1, 2'b01);
        chk("pre_reset_held", held, 2'b01);
        step(0, 2'b01);
        chk("rst_press",   press,       2'b00);
        chk("rst_release", key_release, 2'b00);
        chk("rst_strobe",  strobe,      2'b00);
        chk("rst_held",    held,        2'b00);
        step(1, 2'b01);
        chk("post_rst_press",  press,  2'b01);
        chk("post_rst_strobe", strobe, 2'b01);

        // Random key activity with occasional reset, checked by the model inside step.
        for (int n = 0; n < 400; n++) begin
            bit [1:0] k;
            k = key;
            if ($urandom_range(7) == 0) k[0] = ~k[0];
            if ($urandom_range(7) == 0) k[1] = ~k[1];
            step(($urandom_range(63) != 0), k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
